// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, ALUOp codes,
// state encoding and the decoded opcode class.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_MUL   = 6'b011000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_ORI   = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_MUL_WAIT = 3'd4;
  localparam logic [2:0] S_MEM      = 3'd5;
  localparam logic [2:0] S_WB       = 3'd6;

  typedef struct packed {
    logic rtype;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic jump;
    logic addi;
    logic mul;
    logic illegal;
  } op_class_t;

  // True for any opcode the sequencer knows how to execute.
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_J, OP_ADDI, OP_MUL: op_is_legal = 1'b1;
      default:                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_ctrl_opdecode.sv
// Opcode to one-hot instruction class; anything unrecognised is illegal.
module ctrl_opdecode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  cls
);

  // One-hot class decode of the latched opcode.
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: cls.rtype   = 1'b1;
      OP_ORI:   cls.ori     = 1'b1;
      OP_LW:    cls.lw      = 1'b1;
      OP_SW:    cls.sw      = 1'b1;
      OP_BEQ:   cls.beq     = 1'b1;
      OP_J:     cls.jump    = 1'b1;
      OP_ADDI:  cls.addi    = 1'b1;
      OP_MUL:   cls.mul     = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer: Moore FSM stepping each instruction
// through FETCH/DECODE/EXEC/MEM/WB, stalling on memory ack and multiplier.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ack_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       Jump_o,
  output logic       IRWrite_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       MemToReg_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       ALUSrc_o,
  output logic [1:0] ALUOp_o,
  output logic       MulStart_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fetch_or_idle;
  op_class_t        cls;

  ctrl_opdecode u_opdecode (
    .op  (op_q),
    .cls (cls)
  );

  // Every transition that would enter FETCH checks start_i, so the
  // running instruction always finishes before the FSM parks in IDLE.
  assign fetch_or_idle = start_i ? S_FETCH : S_IDLE;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Jump and illegal opcodes finish here; legality must come from
        // Op_i because op_q is only captured at the end of this cycle.
        if (Op_i == OP_J || !op_is_legal(Op_i)) state_nxt = fetch_or_idle;
        else                                    state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cls.lw || cls.sw)                        state_nxt = S_MEM;
        else if (cls.mul)                            state_nxt = S_MUL_WAIT;
        else if (cls.rtype || cls.ori || cls.addi)   state_nxt = S_WB;
        else if (cls.beq || cls.jump || cls.illegal) state_nxt = fetch_or_idle;
        else                                         state_nxt = fetch_or_idle;
      end
      S_MUL_WAIT: begin
        // A counter already at zero can only come from a corrupted state;
        // leaving on it avoids a permanent stall.
        if (cnt <= CNT_ONE) state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ack_i) state_nxt = cls.lw ? S_WB : fetch_or_idle;
      end
      S_WB: begin
        state_nxt = fetch_or_idle;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched opcode and multiplier wait counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= Op_i;
      if (state == S_EXEC && cls.mul)               cnt <= CNT_INIT;
      else if (state == S_MUL_WAIT && cnt != '0)    cnt <= cnt - CNT_ONE;
    end
  end

  // Moore output decode; only DECODE looks at Op_i, for the jump strobes.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    Jump_o        = 1'b0;
    IRWrite_o     = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemToReg_o    = 1'b0;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    ALUSrc_o      = 1'b0;
    ALUOp_o       = ALUOP_ADD;
    MulStart_o    = 1'b0;
    busy_o        = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        IRWrite_o = 1'b1;
        PCWrite_o = 1'b1;
        ALUOp_o   = ALUOP_ADD;
        ALUSrc_o  = 1'b0;
      end
      S_DECODE: begin
        if (Op_i == OP_J) begin
          PCWrite_o = 1'b1;
          Jump_o    = 1'b1;
        end
      end
      S_EXEC: begin
        RegDst_o      = cls.rtype | cls.mul;
        ALUSrc_o      = cls.ori | cls.lw | cls.sw | cls.addi;
        PCWriteCond_o = cls.beq;
        MulStart_o    = cls.mul;
        if (cls.rtype)    ALUOp_o = ALUOP_RTYPE;
        else if (cls.ori) ALUOp_o = ALUOP_ORI;
        else if (cls.beq) ALUOp_o = ALUOP_BEQ;
        else              ALUOp_o = ALUOP_ADD;
      end
      S_MEM: begin
        MemRead_o  = cls.lw;
        MemWrite_o = cls.sw;
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = cls.rtype | cls.mul;
        MemToReg_o = cls.lw;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction trace model,
// table of instruction-level vectors, and reset / start corner cases.
module tb_multicycle_control;

  localparam int unsigned MC = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_MUL  = 6'b011000;

  typedef logic [13:0] ow_t;

  logic       clk = 1'b0;
  logic       rst_i, start_i, mem_ack_i;
  logic [5:0] Op_i;
  logic       PCWrite_o, PCWriteCond_o, Jump_o, IRWrite_o, MemRead_o, MemWrite_o;
  logic       MemToReg_o, RegWrite_o, RegDst_o, ALUSrc_o, MulStart_o, busy_o;
  logic [1:0] ALUOp_o;
  ow_t        obs;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .Jump_o(Jump_o),
    .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o), .RegDst_o(RegDst_o),
    .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o), .MulStart_o(MulStart_o), .busy_o(busy_o)
  );

  assign obs = {PCWrite_o, PCWriteCond_o, Jump_o, IRWrite_o, MemRead_o, MemWrite_o,
                MemToReg_o, RegWrite_o, RegDst_o, ALUSrc_o, ALUOp_o, MulStart_o, busy_o};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == T_R || op == T_ORI || op == T_LW || op == T_SW ||
           op == T_BEQ || op == T_J || op == T_ADDI || op == T_MUL;
  endfunction

  // Expected output word for one cycle of a running instruction (busy=1).
  function automatic ow_t mk(input logic pcw, pcwc, j, irw, mr, mw, m2r, rw, rd, as,
                             input logic [1:0] aop, input logic ms);
    return {pcw, pcwc, j, irw, mr, mw, m2r, rw, rd, as, aop, ms, 1'b1};
  endfunction

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    ow_t        exp;
    logic       ack;
    logic [5:0] op;
  } cyc_t;

  cyc_t q[$];

  function automatic logic noise(input logic en);
    return en ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Appends the full expected cycle trace of one instruction; d is the
  // number of MEM cycles that pass before the acknowledge arrives.
  task automatic model_instr(input logic [5:0] op, input int unsigned d, input logic nz);
    logic r, ori, lw, sw, beq, j, addi, mul, ill;
    logic [1:0] aop;
    r = op == T_R;  ori = op == T_ORI; lw  = op == T_LW;   sw  = op == T_SW;
    beq = op == T_BEQ; j = op == T_J;  addi = op == T_ADDI; mul = op == T_MUL;
    ill = !is_legal(op);
    q.push_back('{mk(1,0,0,1,0,0,0,0,0,0,2'b00,0), noise(nz), op});
    q.push_back('{mk(j,0,j,0,0,0,0,0,0,0,2'b00,0), noise(nz), op});
    if (j || ill) return;
    aop = r ? 2'b11 : ori ? 2'b10 : beq ? 2'b01 : 2'b00;
    q.push_back('{mk(0,beq,0,0,0,0,0,0,r|mul,ori|lw|sw|addi,aop,mul), noise(nz), op});
    if (beq) return;
    if (mul) begin
      for (int unsigned i = 0; i < MC; i++)
        q.push_back('{mk(0,0,0,0,0,0,0,0,0,0,2'b00,0), noise(nz), op});
      q.push_back('{mk(0,0,0,0,0,0,0,1,1,0,2'b00,0), noise(nz), op});
      return;
    end
    if (lw || sw) begin
      for (int unsigned i = 0; i <= d; i++)
        q.push_back('{mk(0,0,0,0,lw,sw,0,0,0,0,2'b00,0), (i == d), op});
      if (sw) return;
    end
    q.push_back('{mk(0,0,0,0,0,0,lw,1,r,0,2'b00,0), noise(nz), op});
  endtask

  task automatic run_queue();
    int unsigned k = 0;
    while (q.size() != 0) begin
      cyc_t c;
      c = q.pop_front();
      @(posedge clk); #1;
      Op_i = c.op;
      mem_ack_i = c.ack;
      @(negedge clk);
      check($sformatf("trace cyc%0d op=%b", k, c.op), 32'(obs), 32'(c.exp));
      k++;
    end
  endtask

  // ---------------- instruction-level vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    int unsigned d;
    int unsigned len, rw, mr, mw, m2r, ms, pwc, jmp;
  } vec_t;

  vec_t tab[12];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [5:0] rop;
    int unsigned n, rwseen, memseen;
    bit done;

    tab[0]  = '{"rtype",   T_R,    0, 4, 1, 0, 0, 0, 0, 0, 0};
    tab[1]  = '{"ori",     T_ORI,  0, 4, 1, 0, 0, 0, 0, 0, 0};
    tab[2]  = '{"addi",    T_ADDI, 0, 4, 1, 0, 0, 0, 0, 0, 0};
    tab[3]  = '{"lw_ack3", T_LW,   2, 7, 1, 3, 0, 1, 0, 0, 0};
    tab[4]  = '{"lw_ack1", T_LW,   0, 5, 1, 1, 0, 1, 0, 0, 0};
    tab[5]  = '{"sw_ack1", T_SW,   0, 4, 0, 0, 1, 0, 0, 0, 0};
    tab[6]  = '{"sw_ack2", T_SW,   1, 5, 0, 0, 2, 0, 0, 0, 0};
    tab[7]  = '{"beq",     T_BEQ,  0, 3, 0, 0, 0, 0, 0, 1, 0};
    tab[8]  = '{"jump",    T_J,    0, 2, 0, 0, 0, 0, 0, 0, 1};
    tab[9]  = '{"ill_3f",  6'h3f,  0, 2, 0, 0, 0, 0, 0, 0, 0};
    tab[10] = '{"ill_15",  6'h15,  0, 2, 0, 0, 0, 0, 0, 0, 0};
    tab[11] = '{"mul",     T_MUL,  0, 4 + MC, 1, 0, 0, 0, 1, 0, 0};

    // Reset and IDLE
    rst_i = 1'b0; start_i = 1'b0; Op_i = '0; mem_ack_i = 1'b0;
    #1 check("reset_outputs", 32'(obs), 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk); check("idle_outputs", 32'(obs), 0);
    @(negedge clk); check("idle_no_start", 32'(obs), 0);
    start_i = 1'b1;

    // R-type with no ack activity, then a random program
    model_instr(T_R, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rop = T_R;   1: rop = T_ORI;  2: rop = T_LW;   3: rop = T_SW;
        4: rop = T_BEQ; 5: rop = T_J;    6: rop = T_ADDI; 7: rop = T_MUL;
        default: begin
          do rop = 6'($urandom); while (is_legal(rop));
        end
      endcase
      model_instr(rop, $urandom_range(0, 3), 1'b1);
    end
    run_queue();

    // Table vectors; each record starts on a FETCH cycle
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(negedge clk); check("sync_fetch", 32'(IRWrite_o), 1);
    foreach (tab[t]) begin
      int unsigned len, rw, mr, mw, m2r, ms, pwc, jmp;
      len = 1; rw = 0; mr = 0; mw = 0; m2r = 0; ms = 0; pwc = 0; jmp = 0;
      memseen = 0; done = 0;
      Op_i = tab[t].op;
      for (int k = 0; k < 40 && !done; k++) begin
        @(posedge clk); #1;
        mem_ack_i = (MemRead_o | MemWrite_o) && (memseen == tab[t].d);
        @(negedge clk);
        if (IRWrite_o) done = 1;
        else begin
          len++;
          rw += RegWrite_o; mr += MemRead_o; mw += MemWrite_o; m2r += MemToReg_o;
          ms += MulStart_o; pwc += PCWriteCond_o; jmp += Jump_o;
          if (MemRead_o | MemWrite_o) memseen++;
        end
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: no return to FETCH within 40 cycles", tab[t].name);
      end
      check({tab[t].name, " len"},      len, tab[t].len);
      check({tab[t].name, " regwrite"}, rw,  tab[t].rw);
      check({tab[t].name, " memread"},  mr,  tab[t].mr);
      check({tab[t].name, " memwrite"}, mw,  tab[t].mw);
      check({tab[t].name, " memtoreg"}, m2r, tab[t].m2r);
      check({tab[t].name, " mulstart"}, ms,  tab[t].ms);
      check({tab[t].name, " pcwcond"},  pwc, tab[t].pwc);
      check({tab[t].name, " jump"},     jmp, tab[t].jmp);
    end
    mem_ack_i = 1'b0;

    // start_i dropped during MUL_WAIT: mul completes, then IDLE
    Op_i = T_MUL; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      if (MulStart_o) done = 1;
    end
    check("muldrop_start_seen", 32'(done), 1);
    @(posedge clk); @(negedge clk);
    check("muldrop_pulse_single", 32'(MulStart_o), 0);
    check("muldrop_in_wait", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,2'b00,0)));
    start_i = 1'b0;
    n = 0; rwseen = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (RegWrite_o) begin
        rwseen++;
        check("muldrop_wb_regdst", 32'(RegDst_o), 1);
      end
      if (!busy_o) done = 1;
    end
    check("muldrop_cycles_to_idle", n, 5);
    check("muldrop_wb_count", rwseen, 1);
    repeat (3) @(negedge clk);
    check("muldrop_idle_stays", 32'(obs), 0);

    // Reset pulsed during MEM of lw
    start_i = 1'b1; Op_i = T_LW; mem_ack_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_lw_fetch", 32'(IRWrite_o), 1);
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      if (MemRead_o) done = 1;
    end
    check("rst_lw_memread_seen", 32'(done), 1);
    #2 rst_i = 1'b0;
    #1 check("rst_lw_async_drop", 32'(obs), 0);
    repeat (2) @(negedge clk);
    check("rst_lw_held_idle", 32'(obs), 0);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_lw_restart_fetch", 32'(obs), 32'(mk(1,0,0,1,0,0,0,0,0,0,2'b00,0)));
    @(negedge clk);
    check("rst_lw_no_reissue", 32'(MemRead_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
